// File: rtl/aes_pkg.sv
// Shared AES datapath constants and state byte-layout helpers.
// The state word is four 32-bit columns; column c occupies [32c+31:32c]
// and row r of that column occupies byte [8r+7:8r] inside the column.
package aes_pkg;

    localparam int AES_NR_256  = 14;
    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_ROWS    = 4;
    localparam int AES_COLS    = 4;
    localparam int AES_COL_W   = AES_ROWS * AES_BYTE_W;

    // Bit offset of byte (col, row) within a state word.
    function automatic int aes_byte_off(input int col, input int row);
        return col * AES_COL_W + row * AES_BYTE_W;
    endfunction

endpackage

// File: rtl/aes_round_ctr.sv
// Per-block round counter: counts 0..NR, wraps to 0 after NR, and flags
// the final and penultimate rounds for the output tagging logic.
module aes_round_ctr
    import aes_pkg::*;
#(
    parameter int NR = AES_NR_256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] cnt,
    output logic       is_last,
    output logic       is_penult
);

    localparam logic [3:0] LAST_C   = 4'(NR);
    localparam logic [3:0] PENULT_C = 4'(NR - 1);

    // Round index register: abort wins over advance; wrap after the last round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clear) begin
            cnt <= 4'd0;
        end else if (inc) begin
            cnt <= is_last ? 4'd0 : cnt + 4'd1;
        end
    end

    assign is_last   = (cnt == LAST_C);
    assign is_penult = (cnt == PENULT_C);

endmodule

// File: rtl/addroundkey_stage.sv
// Registered AddRoundKey stage: joins the state and round-key streams,
// XORs them, and tags the registered result with its round index so the
// round controller knows when the next round must skip mixcolumn.
module addroundkey_stage
    import aes_pkg::*;
#(
    parameter int NR = AES_NR_256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic [AES_STATE_W-1:0] state_i,
    input  logic                   state_valid_i,
    output logic                   state_ready_o,
    input  logic [AES_STATE_W-1:0] rkey_i,
    input  logic                   rkey_valid_i,
    output logic                   rkey_ready_o,
    output logic [AES_STATE_W-1:0] state_o,
    output logic                   state_valid_o,
    input  logic                   state_ready_i,
    output logic [3:0]             round_o,
    output logic                   last_o,
    output logic                   skip_mix_o
);

    logic [AES_STATE_W-1:0] xor_p0;
    logic                   space_p0;
    logic                   fire_p0;
    logic [3:0]             cnt_p0;
    logic                   cnt_last_p0;
    logic                   cnt_penult_p0;

    logic [AES_STATE_W-1:0] state_p1;
    logic                   vld_p1;
    logic [3:0]             round_p1;
    logic                   last_p1;
    logic                   skip_mix_p1;

    // Stage p0: byte-wise key addition and the joint two-input handshake.
    // Each ready depends only on the other stream's valid so both words
    // are taken together or not at all.
    for (genvar c = 0; c < AES_COLS; c++) begin : g_col
        for (genvar r = 0; r < AES_ROWS; r++) begin : g_row
            assign xor_p0[aes_byte_off(c, r) +: AES_BYTE_W] =
                state_i[aes_byte_off(c, r) +: AES_BYTE_W] ^
                rkey_i[aes_byte_off(c, r) +: AES_BYTE_W];
        end
    end

    assign space_p0      = !vld_p1 || state_ready_i;
    assign fire_p0       = state_valid_i && rkey_valid_i && space_p0 && !clear_i;
    assign state_ready_o = rkey_valid_i && space_p0 && !clear_i;
    assign rkey_ready_o  = state_valid_i && space_p0 && !clear_i;

    aes_round_ctr #(
        .NR (NR)
    ) u_round_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_i),
        .inc       (fire_p0),
        .cnt       (cnt_p0),
        .is_last   (cnt_last_p0),
        .is_penult (cnt_penult_p0)
    );

    // Stage p1: output register; abort drops the word, a consumed word
    // without a replacement goes invalid, otherwise everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1    <= '0;
            vld_p1      <= 1'b0;
            round_p1    <= 4'd0;
            last_p1     <= 1'b0;
            skip_mix_p1 <= 1'b0;
        end else if (clear_i) begin
            vld_p1 <= 1'b0;
        end else if (fire_p0) begin
            state_p1    <= xor_p0;
            vld_p1      <= 1'b1;
            round_p1    <= cnt_p0;
            last_p1     <= cnt_last_p0;
            skip_mix_p1 <= cnt_penult_p0;
        end else if (state_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign state_o       = state_p1;
    assign state_valid_o = vld_p1;
    assign round_o       = round_p1;
    assign last_o        = last_p1;
    assign skip_mix_o    = skip_mix_p1;

endmodule

// File: tb/tb_addroundkey_stage.sv
// Scoreboard bench for addroundkey_stage: a reference model pushes the
// expected output word on every accepted pair, and a monitor compares the
// DUT output register against it on every falling edge.
module tb_addroundkey_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic [127:0] s_in;
    logic         svi;
    logic         state_ready_o;
    logic [127:0] k_in;
    logic         rvi;
    logic         rkey_ready_o;
    logic [127:0] state_o;
    logic         state_valid_o;
    logic         sri;
    logic [3:0]   round_o;
    logic         last_o;
    logic         skip_mix_o;

    always #5 clk = ~clk;

    addroundkey_stage #(.NR(14)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clr),
        .state_i       (s_in),
        .state_valid_i (svi),
        .state_ready_o (state_ready_o),
        .rkey_i        (k_in),
        .rkey_valid_i  (rvi),
        .rkey_ready_o  (rkey_ready_o),
        .state_o       (state_o),
        .state_valid_o (state_valid_o),
        .state_ready_i (sri),
        .round_o       (round_o),
        .last_o        (last_o),
        .skip_mix_o    (skip_mix_o)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
        logic         s;
    } exp_t;

    exp_t       q[$];
    int         rlog[$];
    int         errors = 0;
    int         checks = 0;
    logic       m_valid;
    logic [3:0] m_cnt;
    logic       m_fire;

    // Reference model of the output register; the queue holds the word
    // currently expected on the output.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cnt   = 4'd0;
            q.delete();
        end else if (clr) begin
            m_valid = 1'b0;
            m_cnt   = 4'd0;
            q.delete();
        end else begin
            m_fire = svi && rvi && (!m_valid || sri);
            if (m_valid && sri && q.size() > 0) void'(q.pop_front());
            if (m_fire) begin
                q.push_back('{d: s_in ^ k_in, r: m_cnt, l: (m_cnt == 4'd14), s: (m_cnt == 4'd13)});
                m_valid = 1'b1;
                m_cnt   = (m_cnt == 4'd14) ? 4'd0 : m_cnt + 4'd1;
            end else if (sri) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic rv, input logic [127:0] sd, input logic [127:0] kd);
        svi  = sv;
        rvi  = rv;
        s_in = sd;
        k_in = kd;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        sri   = 1'b1;
        drive(1'b0, 1'b0, '0, '0);

        fork
            forever begin
                @(negedge clk);
                chk("valid", 128'(state_valid_o), 128'(m_valid));
                chk("state_ready", 128'(state_ready_o), 128'(rvi && (!m_valid || sri) && !clr));
                chk("rkey_ready", 128'(rkey_ready_o), 128'(svi && (!m_valid || sri) && !clr));
                if (state_valid_o && m_valid && q.size() > 0) begin
                    chk("data", state_o, q[0].d);
                    chk("round", 128'(round_o), 128'(q[0].r));
                    chk("last", 128'(last_o), 128'(q[0].l));
                    chk("skip_mix", 128'(skip_mix_o), 128'(q[0].s));
                    chk("last_vs_round", 128'(last_o), 128'(round_o == 4'd14));
                    chk("skip_vs_round", 128'(skip_mix_o), 128'(round_o == 4'd13));
                    if (sri) rlog.push_back(int'(round_o));
                end
            end
        join_none

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_state", state_o, 128'h0);
        chk("rst_valid", 128'(state_valid_o), 128'h0);
        chk("rst_round", 128'(round_o), 128'h0);
        chk("rst_last", 128'(last_o), 128'h0);
        chk("rst_skip", 128'(skip_mix_o), 128'h0);
        tick();
        rst_n = 1'b1;

        // FIPS-197 C.3 round 0
        drive(1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("fips_state", state_o, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("fips_round", 128'(round_o), 128'h0);
        chk("fips_last", 128'(last_o), 128'h0);
        chk("fips_skip", 128'(skip_mix_o), 128'h0);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Full block plus one: 16 back-to-back pairs
        rlog.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, {16{8'(i)}}, {8{16'hA55A}});
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk("stream_count", 128'(rlog.size()), 128'd16);
        for (int i = 0; i < 16 && i < rlog.size(); i++)
            chk("stream_round", 128'(rlog[i]), 128'(i % 15));

        // Unequal arrival: state waits three cycles for its key
        drive(1'b1, 1'b0, {16{8'hA5}}, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_state_ready", 128'(state_ready_o), 128'h0);
            chk("wait_rkey_ready", 128'(rkey_ready_o), 128'h1);
            chk("wait_no_output", 128'(state_valid_o), 128'h0);
            tick();
        end
        drive(1'b1, 1'b1, {16{8'hA5}}, {16{8'h5A}});
        @(negedge clk);
        chk("join_state_ready", 128'(state_ready_o), 128'h1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("join_valid", 128'(state_valid_o), 128'h1);
        chk("join_state", state_o, {16{8'hFF}});
        chk("join_round", 128'(round_o), 128'h1);
        tick();

        // Backpressure for four cycles with both inputs valid
        sri = 1'b0;
        drive(1'b1, 1'b1, {4{32'hDEADBEEF}}, {4{32'h01234567}});
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_state_ready", 128'(state_ready_o), 128'h0);
            chk("bp_rkey_ready", 128'(rkey_ready_o), 128'h0);
            chk("bp_state", state_o, {4{32'hDF8EFB88}});
            chk("bp_round", 128'(round_o), 128'h2);
            tick();
        end
        sri = 1'b1;
        drive(1'b1, 1'b1, '0, {4{32'h13579BDF}});
        @(negedge clk);
        chk("bp_release_ready", 128'(state_ready_o & rkey_ready_o), 128'h1);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("bp_next_state", state_o, {4{32'h13579BDF}});
        chk("bp_next_round", 128'(round_o), 128'h3);
        tick();

        // Clear at round 7
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, {16{8'(i + 8'h40)}}, {16{8'h11}});
            tick();
        end
        clr = 1'b1;
        @(negedge clk);
        chk("clr_state_ready", 128'(state_ready_o), 128'h0);
        chk("clr_rkey_ready", 128'(rkey_ready_o), 128'h0);
        tick();
        clr = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("clr_valid", 128'(state_valid_o), 128'h0);
        tick();
        drive(1'b1, 1'b1, {16{8'h3C}}, {16{8'hC3}});
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("clr_next_valid", 128'(state_valid_o), 128'h1);
        chk("clr_next_round", 128'(round_o), 128'h0);
        chk("clr_next_state", state_o, {16{8'hFF}});
        tick();

        // Asynchronous reset mid-cycle while round 9 is on the output
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, {16{8'(i)}}, {16{8'h77}});
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        sri = 1'b0;
        @(negedge clk);
        chk("pre_rst_round", 128'(round_o), 128'h9);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, 128'h0);
        chk("arst_valid", 128'(state_valid_o), 128'h0);
        chk("arst_round", 128'(round_o), 128'h0);
        chk("arst_last", 128'(last_o), 128'h0);
        chk("arst_skip", 128'(skip_mix_o), 128'h0);
        #1;
        rst_n = 1'b1;
        sri   = 1'b1;
        tick();
        drive(1'b1, 1'b1, {16{8'h0F}}, {16{8'hF0}});
        tick();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("arst_next_valid", 128'(state_valid_o), 128'h1);
        chk("arst_next_round", 128'(round_o), 128'h0);
        chk("arst_next_state", state_o, {16{8'hFF}});
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addroundkey_stage.md
Name: addroundkey_stage

Overview:
- Registered AddRoundKey stage of the AES-256-CTR round datapath; sits directly downstream of mixcolumn.
- Joins a 128-bit state stream with a 128-bit round-key stream from the key schedule and XORs them.
- Registers the result and tags it with the round index.
- Tracks rounds 0..NR per block and tells the round controller when the next round must bypass mixcolumn.

Parameters:
- NR, 14, number of AES rounds (14 for AES-256); round counter width is 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- clear_i  input  1  synchronous abort: drop output, restart at round 0
- state_i  input  128  state word: column c at [32c+31:32c], row r byte at [8r+7:8r] of the column (same layout as mixcolumn)
- state_valid_i  input  1  state_i valid
- state_ready_o  output  1  state accepted when valid&ready
- rkey_i  input  128  round key, same layout
- rkey_valid_i  input  1  rkey_i valid
- rkey_ready_o  output  1  key accepted when valid&ready
- state_o  output  128  registered state_i ^ rkey_i
- state_valid_o  output  1  state_o valid
- state_ready_i  input  1  downstream ready
- round_o  output  4  round index of state_o (0..NR)
- last_o  output  1  state_o is the final ciphertext-mask word (round_o==NR)
- skip_mix_o  output  1  next round is the final round and must bypass mixcolumn (round_o==NR-1)

Behaviour:
- Reset (async, rst_n=0): state_o=0, state_valid_o=0, round_o=0, last_o=0, skip_mix_o=0, internal round counter=0.
- Space: space = !state_valid_o | state_ready_i.
- Fire: fire = state_valid_i & rkey_valid_i & space & !clear_i.
- Ready outputs:
  - state_ready_o = rkey_valid_i & space & !clear_i.
  - rkey_ready_o = state_valid_i & space & !clear_i.
  - Both are combinational. Neither ready may depend on its own valid.
- Both inputs are consumed in the same cycle or neither is. A lone valid on one input is held and not consumed.
- On fire (1-cycle latency):
  - state_o <= state_i ^ rkey_i, state_valid_o <= 1.
  - round_o <= cnt, last_o <= (cnt==NR), skip_mix_o <= (cnt==NR-1).
  - cnt <= (cnt==NR) ? 0 : cnt+1.
- No fire and state_ready_i=1: state_valid_o <= 0. last_o and skip_mix_o hold their value but are only meaningful while valid.
- No fire and state_ready_i=0: all outputs hold. Full throughput of one word per cycle under continuous valid/ready.
- Round counter wrap: after round NR is emitted, the counter returns to 0, so the next block starts with round 0 (initial key whitening).
- Exactly NR+1 fires per block.
- clear_i=1 (synchronous, highest priority over fire):
  - cnt <= 0, state_valid_o <= 0. No input is accepted in that cycle.
  - state_o may hold stale data.
- Reset mid-block: all state discarded; the next accepted pair is round 0.
- Backpressure: while state_valid_o=1 and state_ready_i=0, no input is accepted. The output is stable until taken.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR_256=14
  - AES_STATE_W=128
  - the state byte-layout helper constants (column/row bit offsets) used by mixcolumn, shiftrows and this block.
- One natural sub-module: aes_round_ctr (4-bit wrap-at-NR counter with clear and increment, emitting is_last and is_penultimate).
- XOR and handshake logic stay in the top.

Test Plan:
- FIPS-197 C.3 round 0: state_i=128'h00112233445566778899aabbccddeeff, rkey_i=128'h000102030405060708090a0b0c0d0e0f, both valid, state_ready_i=1 -> next cycle state_o=128'h00102030405060708090a0b0c0d0e0f0, round_o=0, last_o=0, skip_mix_o=0.
- Full block, streaming 15 pairs back-to-back -> round_o steps 0..14 on consecutive cycles. skip_mix_o=1 only on round_o=13, last_o=1 only on round_o=14. The 16th pair emits round_o=0.
- Unequal arrival: state_valid_i=1 for 3 cycles before rkey_valid_i -> state_ready_o=0 and rkey_ready_o=1 during the wait, no output. The output appears one cycle after rkey_valid_i rises.
- Backpressure: hold state_ready_i=0 for 4 cycles with both inputs valid -> state_o and round_o stable, both readies 0. The next pair is accepted in the same cycle state_ready_i returns to 1.
- clear_i asserted at round 7 with both inputs valid -> that pair is not accepted and state_valid_o=0 next cycle. The next pair emits round_o=0.
- rst_n pulsed low asynchronously mid-cycle at round 9 -> outputs are 0 immediately. After release, the next pair emits round_o=0.
